// File: rtl/shift_fir.sv
// Shift-and-add FIR: each tap contributes its history sample right-shifted by a
// per-tap amount; the two-stage pipeline registers the terms, then sums and saturates.
module shift_fir #(
  parameter  int DW   = 8,
  parameter  int TAPS = 4,
  parameter  int SW   = 3,
  localparam int AW   = (TAPS > 2) ? $clog2(TAPS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] x,
  input  logic          in_valid,
  input  logic          clr,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [SW-1:0] cfg_shift,
  input  logic          cfg_en,
  output logic [DW-1:0] y,
  output logic          out_valid,
  output logic          out_sat
);

  // Handshake: no backpressure. A sample is taken on any edge where in_valid=1
  // and clr=0; out_valid is a one-cycle pulse marking a fresh y/out_sat pair.

  localparam int ACCW = DW + $clog2(TAPS);

  function automatic logic [SW-1:0] rst_shift(input int k);
    if (k >= (1 << SW) - 1) return '1;
    else return SW'(k);
  endfunction

  logic [DW-1:0]   hist_q [TAPS-1];
  logic [SW-1:0]   shift_q [TAPS];
  logic [TAPS-1:0] en_q;
  logic [DW-1:0]   s_cur [TAPS];
  logic [DW-1:0]   term_d [TAPS];
  logic [DW-1:0]   term_q [TAPS];
  logic            v1_q;
  logic [ACCW-1:0] sum;
  logic            sum_sat;
  logic            accept;

  assign accept = in_valid && !clr;

  // Terms use the configuration registered before this edge, so a same-cycle
  // config write only reaches later samples.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      s_cur[k]  = (k == 0) ? x : hist_q[(k == 0) ? 0 : k - 1];
      term_d[k] = '0;
      if (en_q[k] && int'(shift_q[k]) < DW) term_d[k] = s_cur[k] >> shift_q[k];
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + {{(ACCW-DW){1'b0}}, term_q[k]};
    sum_sat = (sum[ACCW-1:DW] != '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < TAPS - 1; k++) hist_q[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < TAPS - 1; k++) hist_q[k] <= '0;
    end else if (accept) begin
      hist_q[0] <= x;
      for (int k = 1; k < TAPS - 1; k++) hist_q[k] <= hist_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < TAPS; k++) term_q[k] <= '0;
      v1_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < TAPS; k++) term_q[k] <= term_d[k];
      end
      v1_q <= accept;
    end
  end

  // y/out_sat only move when a result lands; clr drops the stage-1 result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      y         <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1_q && !clr;
      if (v1_q && !clr) begin
        y       <= sum_sat ? {DW{1'b1}} : sum[DW-1:0];
        out_sat <= sum_sat;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < TAPS; k++) shift_q[k] <= rst_shift(k);
      en_q <= '1;
    end else if (cfg_we && int'(cfg_addr) < TAPS) begin
      shift_q[cfg_addr] <= cfg_shift;
      en_q[cfg_addr]    <= cfg_en;
    end
  end

endmodule

// File: tb/tb_shift_fir.sv
// Bench for shift_fir: reference model feeds an expected queue at drive time;
// a negedge monitor pops and compares results, latency and hold behaviour.
module tb_shift_fir;

  localparam int DW   = 8;
  localparam int TAPS = 4;
  localparam int SW   = 3;
  localparam int AW   = 2;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] x;
  logic          in_valid;
  logic          clr;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [SW-1:0] cfg_shift;
  logic          cfg_en;
  logic [DW-1:0] y;
  logic          out_valid;
  logic          out_sat;

  shift_fir #(.DW(DW), .TAPS(TAPS), .SW(SW)) dut (
    .CLK(CLK), .RST(RST), .x(x), .in_valid(in_valid), .clr(clr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_shift(cfg_shift), .cfg_en(cfg_en),
    .y(y), .out_valid(out_valid), .out_sat(out_sat)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboard state
  logic [DW:0]   exp_q[$];
  int            due_q[$];
  logic [DW-1:0] last_y   = '0;
  logic          last_sat = 1'b0;
  int            checks   = 0;
  int            failures = 0;

  // reference model state
  logic [DW-1:0] m_hist [TAPS-1];
  int            m_sh [TAPS];
  bit            m_en [TAPS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS - 1; k++) m_hist[k] = '0;
    for (int k = 0; k < TAPS; k++) begin
      m_sh[k] = (k > 7) ? 7 : k;
      m_en[k] = 1'b1;
    end
  endtask

  function automatic logic [DW:0] model(input logic [DW-1:0] xv);
    int sum;
    int s;
    sum = 0;
    for (int k = 0; k < TAPS; k++) begin
      s = (k == 0) ? int'(xv) : int'(m_hist[(k == 0) ? 0 : k - 1]);
      if (m_en[k] && m_sh[k] < DW) sum += s >> m_sh[k];
    end
    if (sum > (1 << DW) - 1) return {1'b1, {DW{1'b1}}};
    return {1'b0, sum[DW-1:0]};
  endfunction

  // driver: called at a negedge, applies inputs for the next posedge, returns at the following negedge
  task automatic drive(input logic [DW-1:0] xv, input logic v, input logic c = 1'b0,
                       input logic we = 1'b0, input int addr = 0, input int sh = 0,
                       input logic en = 1'b1);
    x = xv; in_valid = v; clr = c;
    cfg_we = we; cfg_addr = AW'(addr); cfg_shift = SW'(sh); cfg_en = en;
    if (c) begin
      for (int k = 0; k < TAPS - 1; k++) m_hist[k] = '0;
      while (due_q.size() > 0 && due_q[due_q.size()-1] > cyc) begin
        void'(due_q.pop_back());
        void'(exp_q.pop_back());
      end
    end else if (v) begin
      exp_q.push_back(model(xv));
      due_q.push_back(cyc + 2);
      for (int k = TAPS - 2; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = xv;
    end
    if (we && addr < TAPS) begin
      m_sh[addr] = sh;
      m_en[addr] = en;
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0);
  endtask

  // monitor
  logic [DW:0] mon_e;
  int          mon_d;
  always @(negedge CLK) begin
    if (RST) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          mon_d = due_q.pop_front();
          check("y", y, mon_e[DW-1:0]);
          check("out_sat", out_sat, mon_e[DW]);
          check("latency", cyc, mon_d);
          last_y   = mon_e[DW-1:0];
          last_sat = mon_e[DW];
        end
      end else begin
        check("y_hold", y, last_y);
        check("sat_hold", out_sat, last_sat);
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          check("missing_valid", 32'd0, 32'd1);
          void'(due_q.pop_front());
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    RST = 1'b0; x = '0; in_valid = 1'b0; clr = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0; cfg_en = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_y", y, 32'd0);
    check("rst_valid", out_valid, 32'd0);
    check("rst_sat", out_sat, 32'd0);
    RST = 1'b1;

    // impulse with default taps: 8,4,2,1,0
    drive(8'd8, 1'b1);
    for (int i = 0; i < 4; i++) drive(8'd0, 1'b1);
    idle(3);

    // saturation from a clean history
    drive('0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(8'd255, 1'b1);
    idle(3);

    // bubbles: acceptance every other cycle
    drive('0, 1'b0, 1'b1);
    drive(8'd8, 1'b1); idle(1);
    for (int i = 0; i < 4; i++) begin drive(8'd0, 1'b1); idle(1); end
    idle(2);

    // coefficient change: tap1 shift 0, tap3 disabled, impulse 16 -> 16,16,4,0
    drive('0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0);
    drive('0, 1'b0, 1'b1);
    drive(8'd16, 1'b1);
    for (int i = 0; i < 3; i++) drive(8'd0, 1'b1);
    idle(3);

    // config write colliding with acceptance keeps the old tap0 coefficient
    drive('0, 1'b0, 1'b1);
    drive(8'd8, 1'b1, 1'b0, 1'b1, 0, 1, 1'b1);
    drive(8'd0, 1'b1);
    drive(8'd8, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    idle(3);

    // clr with a sample drops it and flushes history; config write alongside still lands
    drive(8'd100, 1'b1);
    drive(8'd77, 1'b1, 1'b1, 1'b1, 3, 3, 1'b1);
    drive(8'd8, 1'b1);
    idle(3);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive(DW'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
    end
    idle(3);

    // reset mid-stream with non-default config
    drive('0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1);
    drive(8'd50, 1'b1);
    drive(8'd200, 1'b1);
    RST = 1'b0;
    exp_q.delete();
    due_q.delete();
    model_reset();
    last_y = '0;
    last_sat = 1'b0;
    #1;
    check("midrst_y", y, 32'd0);
    check("midrst_valid", out_valid, 32'd0);
    check("midrst_sat", out_sat, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    drive(8'd8, 1'b1);
    for (int i = 0; i < 4; i++) drive(8'd0, 1'b1);
    idle(4);

    check("drain_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
